// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared types for the TLB refill controller: address/PTE types and FSM states.
package common;

  localparam int VPN_W  = 20;
  localparam int PPN_W  = 8;
  localparam int PPTR_W = 20;

  typedef logic [VPN_W-1:0]  vpn_t;
  typedef logic [PPN_W-1:0]  ppn_t;
  typedef logic [PPTR_W-1:0] pptr_t;

  typedef struct packed {
    logic [31-PPN_W-1:0] rsvd;
    ppn_t                ppn;
    logic                valid;
  } pte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } state_e;

  // PTE physical address, wrapped to the physical pointer width
  function automatic pptr_t pte_addr(input pptr_t base, input vpn_t vpn, input int unsigned shift);
    return base + pptr_t'(vpn << shift);
  endfunction

endpackage

// File: rtl/tlb_refill_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; index 0 = ITLB, 1 = DTLB. Reset pointer favours DTLB.
module rr_arbiter2
  import common::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_r;

  // grant the requester not served last when both are asking
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last_r;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end else begin
      gnt_idx = 1'b0;
    end
  end

  // last-served pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b0;
    end else if (take && gnt_valid) begin
      last_r <= gnt_idx;
    end
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// Page-table walker refilling ITLB/DTLB from single-level PTEs.
// Optional: define TLB_REFILL_PF_EN to turn invalid PTEs (bit0=0) into page faults.
module tlb_refill_ctrl
  import common::*;
#(
  parameter int PTE_SHIFT = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        itlb_miss,
  input  vpn_t        itlb_vpn,
  input  logic        dtlb_miss,
  input  vpn_t        dtlb_vpn,
  input  pptr_t       ptbr,
  input  logic        flush,
  output logic        mem_req,
  output pptr_t       mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        itlb_write_en,
  output logic        dtlb_write_en,
  output vpn_t        write_vpn,
  output ppn_t        write_ppn,
  output logic        busy,
  output logic        fault,
  output logic        fault_src
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_r, state_nxt_s;
  logic [1:0]         pend_r, pend_nxt_s, clr_s;
  vpn_t               ivpn_r, dvpn_r, gvpn_s;
  logic               gidx_r;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic               arb_valid_s, arb_idx_s, arb_take_s;
  logic               cnt_last_s, timeout_s, fill_go_s, fill_ok_s;
  pte_t               pte_s;
  logic               unused_s;
  logic               mem_req_s, itlb_we_s, dtlb_we_s, busy_s, fault_s, fault_src_s;
  pptr_t              mem_addr_s;
  vpn_t               write_vpn_s;
  ppn_t               write_ppn_s;

  assign pte_s      = pte_t'(mem_rdata);
  assign unused_s   = ^{pte_s.rsvd, pte_s.valid};
  assign gvpn_s     = gidx_r ? dvpn_r : ivpn_r;
  assign cnt_last_s = (wait_cnt_r == CNT_W'(TIMEOUT - 1));
  assign timeout_s  = (state_r == ST_WAIT) && !flush && !mem_rvalid && cnt_last_s;
  assign fill_go_s  = (state_r == ST_WAIT) && (state_nxt_s == ST_FILL);
  assign arb_take_s = (state_r == ST_IDLE) && (state_nxt_s == ST_REQ);

`ifdef TLB_REFILL_PF_EN
  assign fill_ok_s = pte_s.valid;
`else
  assign fill_ok_s = 1'b1;
`endif

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (pend_r),
    .take      (arb_take_s),
    .gnt_valid (arb_valid_s),
    .gnt_idx   (arb_idx_s)
  );

  // state register, granted index and WAIT cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gidx_r     <= 1'b0;
      wait_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (arb_take_s) begin
        gidx_r <= arb_idx_s;
      end
      if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = arb_valid_s ? ST_REQ : ST_IDLE;
        ST_REQ:  state_nxt_s = mem_gnt ? ST_WAIT : ST_REQ;
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_nxt_s = ST_FILL;
          end else if (cnt_last_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_FILL: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // pending flags: clearing in FILL also masks the TLB's lagging miss
  always_comb begin
    clr_s = 2'b00;
    if ((state_r == ST_FILL) || timeout_s) begin
      clr_s[gidx_r] = 1'b1;
    end else begin
      clr_s = 2'b00;
    end
    if (flush) begin
      pend_nxt_s = 2'b00;
    end else begin
      pend_nxt_s = (pend_r | {dtlb_miss, itlb_miss}) & ~clr_s;
    end
  end

  // pending flags and VPN capture (VPN only re-latched while its flag is clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= 2'b00;
      ivpn_r <= '0;
      dvpn_r <= '0;
    end else begin
      pend_r <= pend_nxt_s;
      if (itlb_miss && !pend_r[0]) begin
        ivpn_r <= itlb_vpn;
      end
      if (dtlb_miss && !pend_r[1]) begin
        dvpn_r <= dtlb_vpn;
      end
    end
  end

  // next values of the registered outputs, derived from the upcoming state
  always_comb begin
    mem_req_s   = (state_nxt_s == ST_REQ);
    busy_s      = (state_nxt_s != ST_IDLE);
    itlb_we_s   = 1'b0;
    dtlb_we_s   = 1'b0;
    fault_s     = 1'b0;
    fault_src_s = fault_src;
    write_vpn_s = write_vpn;
    write_ppn_s = write_ppn;
    if (arb_take_s) begin
      mem_addr_s = pte_addr(ptbr, arb_idx_s ? dvpn_r : ivpn_r, PTE_SHIFT);
    end else begin
      mem_addr_s = mem_addr;
    end
    if (fill_go_s && fill_ok_s) begin
      itlb_we_s   = ~gidx_r;
      dtlb_we_s   = gidx_r;
      write_vpn_s = gvpn_s;
      write_ppn_s = pte_s.ppn;
    end else if (fill_go_s || timeout_s) begin
      fault_s     = 1'b1;
      fault_src_s = gidx_r;
    end else begin
      fault_s = 1'b0;
    end
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      itlb_write_en <= 1'b0;
      dtlb_write_en <= 1'b0;
      write_vpn     <= '0;
      write_ppn     <= '0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      fault_src     <= 1'b0;
    end else begin
      mem_req       <= mem_req_s;
      mem_addr      <= mem_addr_s;
      itlb_write_en <= itlb_we_s;
      dtlb_write_en <= dtlb_we_s;
      write_vpn     <= write_vpn_s;
      write_ppn     <= write_ppn_s;
      busy          <= busy_s;
      fault         <= fault_s;
      fault_src     <= fault_src_s;
    end
  end

endmodule
